// File: rtl/ram_readback_pkg.sv
// ram_readback_pkg
// Shared definitions for the program-RAM readback engine.
// - rb_state_t : readback FSM state encoding
// - RB_READ_LAT_DEFAULT : default RAM read latency, also used by the
//   top-level RAM address mux so both sides agree on timing
// - rb_owns_bus() : true while the reader drives the RAM address/rden,
//   the mux select for handing the RAM port to this block
package ram_readback_pkg;

    typedef enum logic [2:0] {
        RB_IDLE  = 3'd0,
        RB_ISSUE = 3'd1,
        RB_WAIT  = 3'd2,
        RB_HOLD  = 3'd3,
        RB_DONE  = 3'd4
    } rb_state_t;

    localparam int RB_ADDR_W_DEFAULT   = 10;
    localparam int RB_DATA_W_DEFAULT   = 16;
    localparam int RB_READ_LAT_DEFAULT = 1;

    // Wide enough for read latencies 1..3.
    localparam int RB_WAIT_CNT_W = 2;

    function automatic logic rb_owns_bus(input rb_state_t s);
        return (s == RB_ISSUE) || (s == RB_WAIT) || (s == RB_HOLD);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// One-flop rising-edge detector for an already synchronized level input.
// The previous sample is registered; rise is high for the cycle in which
// sig is 1 and its registered copy is still 0.
// Ports:
//   clk  in  clock
//   srst in  synchronous active-high reset (clears the history flop)
//   sig  in  synchronized level input
//   rise out one-cycle pulse on a 0->1 transition of sig
module rise_detect (
    input  logic clk,
    input  logic srst,
    input  logic sig,
    output logic rise
);

    logic sig_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sig_reg <= 1'b0;
        end else begin
            sig_reg <= sig;
        end
    end

    // A level held across many cycles produces exactly one pulse.
    assign rise = sig & ~sig_reg;

endmodule

// File: rtl/ram_readback.sv
// ram_readback
// Sequential reader for the on-chip program RAM. On Start it walks the
// inclusive address range Start_ADDR..Last_ADDR (wrapping at the top of the
// address space), issues one single-cycle read per word, captures the word
// READ_LAT cycles later and presents it with its address. A running 16-bit
// checksum of the captured words lets a loaded image be verified on board.
// In step mode (Mode=0) it pauses after every word until a Step press; in
// sweep mode (Mode=1) it runs freely at one word per 1+READ_LAT cycles.
//
// Ports:
//   Clk            in  system clock
//   Reset          in  synchronous active-high reset
//   Start          in  level; begins a pass when idle or done
//   Mode           in  0 = step, 1 = sweep
//   Step           in  synchronized button; rising edge advances in step mode
//   Start_ADDR     in  first address of the pass (latched on Start)
//   Last_ADDR      in  final address, inclusive (latched on Start)
//   Data_from_SRAM in  RAM read data
//   ADDR           out RAM address (registered)
//   rden           out RAM read enable (registered, one cycle per word)
//   Word           out last captured word
//   Word_ADDR      out address of Word
//   Word_valid     out one-cycle pulse per captured word
//   Checksum       out running sum of captured words, modulo 2^DATA_W
//   Busy           out high while the reader owns the RAM port
//   Done           out high once the pass completes, until next Start/Reset
module ram_readback
    import ram_readback_pkg::*;
#(
    parameter int ADDR_W   = RB_ADDR_W_DEFAULT,
    parameter int DATA_W   = RB_DATA_W_DEFAULT,
    parameter int READ_LAT = RB_READ_LAT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic              Step,
    input  logic [ADDR_W-1:0] Start_ADDR,
    input  logic [ADDR_W-1:0] Last_ADDR,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic [ADDR_W-1:0] ADDR,
    output logic              rden,
    output logic [DATA_W-1:0] Word,
    output logic [ADDR_W-1:0] Word_ADDR,
    output logic              Word_valid,
    output logic [DATA_W-1:0] Checksum,
    output logic              Busy,
    output logic              Done
);

    localparam logic [RB_WAIT_CNT_W-1:0] WAIT_INIT = RB_WAIT_CNT_W'(READ_LAT);
    localparam logic [ADDR_W-1:0]        ADDR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rb_state_t                state_reg,      state_next;
    logic [ADDR_W-1:0]        addr_reg,       addr_next;
    logic [ADDR_W-1:0]        last_addr_reg,  last_addr_next;
    logic                     rden_reg,       rden_next;
    logic [RB_WAIT_CNT_W-1:0] wait_cnt_reg,   wait_cnt_next;
    logic [DATA_W-1:0]        word_reg,       word_next;
    logic [ADDR_W-1:0]        word_addr_reg,  word_addr_next;
    logic                     word_valid_reg, word_valid_next;
    logic [DATA_W-1:0]        checksum_reg,   checksum_next;

    logic step_rise;
    logic capture;
    logic at_last;

    // ------------------------------------------------------------------
    // Step edge detection. The pulse only lasts one cycle, so an edge that
    // arrives while the FSM is still issuing/waiting is gone by the time
    // HOLD is entered and cannot advance the next word.
    // ------------------------------------------------------------------
    rise_detect u_step_rise (
        .clk  (Clk),
        .srst (Reset),
        .sig  (Step),
        .rise (step_rise)
    );

    // The last WAIT cycle is the one in which the RAM data is valid.
    assign capture = (state_reg == RB_WAIT) && (wait_cnt_reg <= 1);
    assign at_last = (addr_reg == last_addr_reg);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        last_addr_next  = last_addr_reg;
        rden_next       = 1'b0;
        wait_cnt_next   = wait_cnt_reg;
        word_next       = word_reg;
        word_addr_next  = word_addr_reg;
        word_valid_next = 1'b0;
        checksum_next   = checksum_reg;

        unique case (state_reg)
            RB_IDLE, RB_DONE: begin
                if (Start) begin
                    // Start is only honoured here; while busy it is ignored.
                    last_addr_next = Last_ADDR;
                    addr_next      = Start_ADDR;
                    checksum_next  = '0;
                    word_next      = '0;
                    word_addr_next = '0;
                    rden_next      = 1'b1;
                    state_next     = RB_ISSUE;
                end
            end

            RB_ISSUE: begin
                wait_cnt_next = WAIT_INIT;
                state_next    = RB_WAIT;
            end

            RB_WAIT: begin
                if (capture) begin
                    word_next       = Data_from_SRAM;
                    word_addr_next  = addr_reg;
                    checksum_next   = checksum_reg + Data_from_SRAM;
                    word_valid_next = 1'b1;
                    if (at_last) begin
                        state_next = RB_DONE;
                    end else if (Mode) begin
                        // Address arithmetic wraps naturally at 2^ADDR_W.
                        addr_next  = addr_reg + ADDR_ONE;
                        rden_next  = 1'b1;
                        state_next = RB_ISSUE;
                    end else begin
                        state_next = RB_HOLD;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end

            RB_HOLD: begin
                // Switching to sweep mode while paused resumes on its own.
                if (Mode || step_rise) begin
                    addr_next  = addr_reg + ADDR_ONE;
                    rden_next  = 1'b1;
                    state_next = RB_ISSUE;
                end
            end

            default: begin
                state_next = RB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset discards any read in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= RB_IDLE;
            addr_reg       <= '0;
            last_addr_reg  <= '0;
            rden_reg       <= 1'b0;
            wait_cnt_reg   <= '0;
            word_reg       <= '0;
            word_addr_reg  <= '0;
            word_valid_reg <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            last_addr_reg  <= last_addr_next;
            rden_reg       <= rden_next;
            wait_cnt_reg   <= wait_cnt_next;
            word_reg       <= word_next;
            word_addr_reg  <= word_addr_next;
            word_valid_reg <= word_valid_next;
            checksum_reg   <= checksum_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ADDR       = addr_reg;
    assign rden       = rden_reg;
    assign Word       = word_reg;
    assign Word_ADDR  = word_addr_reg;
    assign Word_valid = word_valid_reg;
    assign Checksum   = checksum_reg;
    assign Busy       = rb_owns_bus(state_reg);
    assign Done       = (state_reg == RB_DONE);

endmodule

// File: tb/tb_ram_readback.sv
// tb_ram_readback
// Two readers share one set of control inputs and one RAM image: dut0 with
// a 1-cycle RAM, dut1 with a 2-cycle RAM. A scoreboard holds the address
// sequence each pass must produce (start..last, wrapping) and the running
// checksum built from the RAM image; every Word_valid is checked against it.
module tb_ram_readback;

    logic        Clk = 1'b0;
    logic        Reset, Start, Mode, Step;
    logic [9:0]  start_addr, last_addr;
    logic [15:0] mem [0:1023];

    logic [15:0] q0, q1, q1a;
    logic [9:0]  addr0, addr1, wa0, wa1;
    logic        rden0, rden1, wv0, wv1, busy0, busy1, done0, done1;
    logic [15:0] w0, w1, cs0, cs1;

    always #5 Clk = ~Clk;

    ram_readback #(.ADDR_W(10), .DATA_W(16), .READ_LAT(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Step(Step),
        .Start_ADDR(start_addr), .Last_ADDR(last_addr), .Data_from_SRAM(q0),
        .ADDR(addr0), .rden(rden0), .Word(w0), .Word_ADDR(wa0),
        .Word_valid(wv0), .Checksum(cs0), .Busy(busy0), .Done(done0));

    ram_readback #(.ADDR_W(10), .DATA_W(16), .READ_LAT(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Step(Step),
        .Start_ADDR(start_addr), .Last_ADDR(last_addr), .Data_from_SRAM(q1),
        .ADDR(addr1), .rden(rden1), .Word(w1), .Word_ADDR(wa1),
        .Word_valid(wv1), .Checksum(cs1), .Busy(busy1), .Done(done1));

    // RAM models: registered read, plus one extra output stage for dut1.
    always @(posedge Clk) begin
        if (rden0) q0 <= mem[addr0];
        if (rden1) q1a <= mem[addr1];
        q1 <= q1a;
    end

    // Scoreboard state
    int unsigned exp_q0[$];
    int unsigned exp_q1[$];
    logic [15:0] sum [2];
    int          pulses [2];
    int          last_cyc [2];
    int          start_cyc;
    int          cyc;
    bit          sweep_timing;
    int          n_checks, n_pass;

    typedef struct {
        logic [9:0]  s;
        logic [9:0]  l;
        int          n;
        logic [15:0] csum;
        bit          mid_start;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic mon(input int d, input logic wv, input logic [9:0] wa, input logic [15:0] w,
                       input logic [15:0] cs, input logic busy, input logic done);
        int unsigned a;
        int          rem;
        bit          has;
        int          lat;
        if (wv === 1'b1) begin
            lat = d + 1;
            has = 1'b0;
            a   = 0;
            rem = 0;
            if (d == 0) begin
                if (exp_q0.size() != 0) begin has = 1'b1; a = exp_q0.pop_front(); rem = exp_q0.size(); end
            end else begin
                if (exp_q1.size() != 0) begin has = 1'b1; a = exp_q1.pop_front(); rem = exp_q1.size(); end
            end
            if (!has) begin
                check($sformatf("spurious_word_valid_d%0d", d), {31'd0, wv}, 32'd0);
            end else begin
                sum[d] = sum[d] + mem[a];
                check($sformatf("word_addr_d%0d", d), {22'd0, wa}, a);
                check($sformatf("word_data_d%0d", d), {16'd0, w}, {16'd0, mem[a]});
                check($sformatf("checksum_d%0d", d), {16'd0, cs}, {16'd0, sum[d]});
                if (rem == 0) check($sformatf("busy_done_last_d%0d", d), {30'd0, busy, done}, 32'd1);
                else          check($sformatf("busy_done_mid_d%0d", d), {30'd0, busy, done}, 32'd2);
                if (sweep_timing) begin
                    if (pulses[d] == 0) check($sformatf("first_latency_d%0d", d), cyc - start_cyc, 2 + lat);
                    else                check($sformatf("sweep_gap_d%0d", d), cyc - last_cyc[d], 1 + lat);
                end
            end
            pulses[d]++;
            last_cyc[d] = cyc;
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc++;
        mon(0, wv0, wa0, w0, cs0, busy0, done0);
        mon(1, wv1, wa1, w1, cs1, busy1, done1);
    endtask

    task automatic begin_pass(input logic [9:0] s, input logic [9:0] l, input logic m);
        int unsigned a;
        exp_q0.delete();
        exp_q1.delete();
        a = s;
        for (int k = 0; k < 1024; k++) begin
            exp_q0.push_back(a);
            exp_q1.push_back(a);
            if (a == l) break;
            a = (a + 1) % 1024;
        end
        for (int d = 0; d < 2; d++) begin sum[d] = 16'd0; pulses[d] = 0; end
        start_addr   = s;
        last_addr    = l;
        Mode         = m;
        Start        = 1'b1;
        sweep_timing = m;
        start_cyc    = cyc;
        tick();
        Start = 1'b0;
        check("issue_d0", {19'd0, addr0, rden0, busy0, done0}, {19'd0, s, 3'b110});
        check("issue_d1", {19'd0, addr1, rden1, busy1, done1}, {19'd0, s, 3'b110});
        check("cleared_d0", {w0, cs0}, 32'd0);
        check("cleared_d1", {w1, cs1}, 32'd0);
    endtask

    task automatic wait_done(input int budget, input bit mid);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mid && i == 2) begin Start = 1'b1; start_addr = 10'h2AA; last_addr = 10'h2AB; end
            if (mid && i == 3) Start = 1'b0;
            tick();
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && done0 === 1'b1 && done1 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("pass_completes", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0]  rs, rl;
        int          len;
        logic [15:0] tot;
        bit          found;

        n_checks = 0; n_pass = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin sum[d] = 16'd0; pulses[d] = 0; last_cyc[d] = 0; end
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Step = 1'b0;
        start_addr = '0; last_addr = '0; sweep_timing = 1'b0; start_cyc = 0;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[10'h000] = 16'h1111; mem[10'h001] = 16'h2222;
        mem[10'h002] = 16'h3333; mem[10'h003] = 16'h4444;
        mem[10'h3FE] = 16'h0100; mem[10'h3FF] = 16'h0200;
        mem[10'h020] = 16'hFFFF; mem[10'h021] = 16'h0002;
        mem[10'h005] = 16'h5A5A;

        vecs[0] = '{s: 10'h000, l: 10'h003, n: 4, csum: 16'hAAAA, mid_start: 1'b1};
        vecs[1] = '{s: 10'h3FE, l: 10'h001, n: 4, csum: 16'h3633, mid_start: 1'b0};
        vecs[2] = '{s: 10'h020, l: 10'h021, n: 2, csum: 16'h0001, mid_start: 1'b0};
        vecs[3] = '{s: 10'h005, l: 10'h005, n: 1, csum: 16'h5A5A, mid_start: 1'b0};

        // Reset state
        repeat (3) tick();
        check("reset_ctl_d0", {8'd0, addr0, wa0, rden0, wv0, busy0, done0}, 32'd0);
        check("reset_dat_d0", {w0, cs0}, 32'd0);
        check("reset_ctl_d1", {8'd0, addr1, wa1, rden1, wv1, busy1, done1}, 32'd0);
        check("reset_dat_d1", {w1, cs1}, 32'd0);
        Reset = 1'b0;
        tick();

        // Table-driven sweep passes
        for (int v = 0; v < 4; v++) begin
            begin_pass(vecs[v].s, vecs[v].l, 1'b1);
            wait_done(200, vecs[v].mid_start);
            repeat (3) tick();
            check($sformatf("final_csum_d0_v%0d", v), {16'd0, cs0}, {16'd0, vecs[v].csum});
            check($sformatf("final_csum_d1_v%0d", v), {16'd0, cs1}, {16'd0, vecs[v].csum});
            check($sformatf("word_count_d0_v%0d", v), pulses[0], vecs[v].n);
            check($sformatf("word_count_d1_v%0d", v), pulses[1], vecs[v].n);
            check($sformatf("done_held_v%0d", v), {28'd0, busy0, done0, busy1, done1}, 32'h5);
        end

        // Randomized sweep passes against the range/sum model
        for (int r = 0; r < 6; r++) begin
            rs  = 10'($urandom_range(0, 1023));
            len = $urandom_range(1, 8);
            rl  = 10'((int'(rs) + len - 1) % 1024);
            tot = 16'd0;
            for (int k = 0; k < len; k++) tot = tot + mem[(int'(rs) + k) % 1024];
            begin_pass(rs, rl, 1'b1);
            wait_done(200, 1'b0);
            check($sformatf("rand_csum_d0_r%0d", r), {16'd0, cs0}, {16'd0, tot});
            check($sformatf("rand_csum_d1_r%0d", r), {16'd0, cs1}, {16'd0, tot});
            check($sformatf("rand_count_d0_r%0d", r), pulses[0], len);
        end

        // Step mode: one word per press, a held button counts once
        begin_pass(10'h010, 10'h012, 1'b0);
        repeat (10) tick();
        check("step_first_d0", pulses[0], 1);
        check("step_first_d1", pulses[1], 1);
        check("step_hold_busy", {30'd0, busy0, busy1}, 32'd3);
        Step = 1'b1;
        tick();
        Step = 1'b0;
        repeat (10) tick();
        check("step_press_d0", pulses[0], 2);
        check("step_press_d1", pulses[1], 2);
        Step = 1'b1;
        repeat (50) tick();
        check("step_held_d0", pulses[0], 3);
        check("step_held_d1", pulses[1], 3);
        check("step_done", {30'd0, done0, done1}, 32'd3);
        Step = 1'b0;
        repeat (3) tick();
        check("step_after_done_d0", pulses[0], 3);

        // Step mode, switching to sweep while held resumes without Step
        begin_pass(10'h100, 10'h102, 1'b0);
        repeat (6) tick();
        check("hold_before_mode_d0", pulses[0], 1);
        Mode = 1'b1;
        wait_done(50, 1'b0);
        check("mode_resume_d0", pulses[0], 3);
        check("mode_resume_d1", pulses[1], 3);

        // Reset during the WAIT of the second word
        begin_pass(10'h000, 10'h003, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulses[0] == 1) begin found = 1'b1; break; end
        end
        check("reset_seq_first_word", {31'd0, found}, 32'd1);
        tick();
        check("in_wait_d0", {30'd0, rden0, busy0}, 32'd1);
        Reset = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        tick();
        check("midreset_ctl_d0", {8'd0, addr0, wa0, rden0, wv0, busy0, done0}, 32'd0);
        check("midreset_dat_d0", {w0, cs0}, 32'd0);
        check("midreset_ctl_d1", {8'd0, addr1, wa1, rden1, wv1, busy1, done1}, 32'd0);
        check("midreset_dat_d1", {w1, cs1}, 32'd0);
        Reset = 1'b0;
        repeat (6) tick();
        check("post_reset_idle", {28'd0, busy0, done0, busy1, done1}, 32'd0);
        begin_pass(10'h000, 10'h003, 1'b1);
        wait_done(200, 1'b0);
        check("restart_csum_d0", {16'd0, cs0}, 32'h0000AAAA);
        check("restart_count_d0", pulses[0], 4);
        check("restart_count_d1", pulses[1], 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
